// File: rtl/top_block_sum_if.sv
// top_block_sum_if: memory-side bus of the block summer (32x16 word memory plus ready flag).
interface top_block_sum_if;
    logic [4:0]  addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        read_en;
    logic        write_en;
    logic        ready;
    modport master (output addr, data_in, read_en, write_en, ready, input data_out);
    modport slave  (input addr, data_in, read_en, write_en, ready, output data_out);
endinterface

// File: rtl/top_block_sum.sv
// top_block_sum: for each 8-word block, sums words 0..6 into word 7; one pass is INIT + 4x(7 reads + 1 write) + 4 DONE cycles, repeating forever.
module top_block_sum (
    input logic             clk_i,
    input logic             rst_ni,
    top_block_sum_if.master bus
);
    typedef enum logic [1:0] {INIT, READ, WRITE, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d, din_q, din_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  blk_q, blk_d, cnt_q, cnt_d;
    logic [4:0]  addr_q, addr_d;
    logic        re_q, re_d, we_q, we_d, rdy_q, rdy_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                acc_d   = '0;
                idx_d   = '0;
                blk_d   = '0;
                state_d = READ;
            end
            READ: begin
                acc_d   = acc_q + bus.data_out;
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q == 3'd6) ? WRITE : READ;
            end
            WRITE: begin
                acc_d   = '0;
                idx_d   = '0;
                cnt_d   = '0;
                blk_d   = blk_q + 2'd1;
                state_d = (blk_q == 2'd3) ? DONE : READ;
            end
            DONE: begin
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == 2'd3) ? INIT : DONE;
            end
        endcase
        // Outputs are decoded from the next state so they leave the flops already aligned with it.
        re_d   = (state_d == READ);
        we_d   = (state_d == WRITE);
        rdy_d  = (state_d == DONE);
        addr_d = re_d ? {blk_d, idx_d} : we_d ? {blk_d, 3'd7} : 5'd0;
        din_d  = we_d ? acc_d : 16'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            acc_q   <= '0;
            idx_q   <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            re_q    <= re_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.addr     = addr_q;
    assign bus.data_in  = din_q;
    assign bus.read_en  = re_q;
    assign bus.write_en = we_q;
    assign bus.ready    = rdy_q;
endmodule

// File: tb/tb_top_block_sum.sv
// tb_top_block_sum: directed checks of the block summer against a 32x16 memory model with hand-computed sums.
module tb_top_block_sum;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic load = 1'b0;
    logic mon_en = 1'b0;
    logic [15:0] mem [32] = '{default: 16'h0};
    logic [15:0] preset [32];
    logic [4:0] wr_log [$];
    int n_checks = 0;
    int n_errors = 0;
    int base;

    top_block_sum_if bus ();
    top_block_sum dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

    always #5 clk_i = ~clk_i;

    assign bus.data_out = bus.read_en ? mem[bus.addr] : 16'hzzzz;

    // Operand preloads never touch result words, so stale results stay observable.
    always @(posedge clk_i) begin
        if (load) begin
            for (int i = 0; i < 32; i++) if (i % 8 != 7) mem[i] <= preset[i];
        end else if (bus.write_en) begin
            mem[bus.addr] <= bus.data_in;
            wr_log.push_back(bus.addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) if (mon_en) chk("re_we_excl", {31'd0, bus.read_en & bus.write_en}, 0);

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic load_pattern(input int mode);
        for (int i = 0; i < 32; i++)
            preset[i] = (mode == 0) ? ((i < 8) ? 16'd1 : (i < 16) ? 16'd2 : (i < 24) ? 16'd10 : 16'd5)
                      : (mode == 1) ? 16'(i) : 16'hFFFF;
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    task automatic chk_results(input string tag, input logic [15:0] r0, input logic [15:0] r1,
                               input logic [15:0] r2, input logic [15:0] r3);
        chk({tag, "_m7"},  mem[7],  r0);
        chk({tag, "_m15"}, mem[15], r1);
        chk({tag, "_m23"}, mem[23], r2);
        chk({tag, "_m31"}, mem[31], r3);
    endtask

    task automatic chk_writes(input string tag, input int from);
        chk({tag, "_nwr"}, wr_log.size() - from, 4);
        for (int i = 0; i < 4; i++)
            if (from + i < wr_log.size()) chk({tag, "_wraddr"}, wr_log[from + i], 8 * i + 7);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_addr"}, bus.addr, 0);
        chk({tag, "_din"}, bus.data_in, 0);
        chk({tag, "_re"}, bus.read_en, 0);
        chk({tag, "_we"}, bus.write_en, 0);
        chk({tag, "_rdy"}, bus.ready, 0);
    endtask

    initial begin
        load_pattern(0);
        tick(1);
        chk_idle("rst");
        mon_en = 1'b1;
        base = wr_log.size();
        rst_ni = 1'b1;
        tick(1);
        chk("first_re", bus.read_en, 1);
        chk("first_addr", bus.addr, 0);
        tick(31);
        chk("rdy_low_e32", bus.ready, 0);
        chk("we_e32", bus.write_en, 1);
        chk("addr_e32", bus.addr, 31);
        tick(1);
        chk("rdy_rise_e33", bus.ready, 1);
        chk_results("p1", 16'd7, 16'd14, 16'd70, 16'd35);
        chk_writes("p1", base);
        base = wr_log.size();
        load_pattern(1);
        chk("rdy_e34", bus.ready, 1);
        chk("re_done", bus.read_en, 0);
        tick(1);
        chk("rdy_e35", bus.ready, 1);
        tick(1);
        chk("rdy_e36", bus.ready, 1);
        tick(1);
        chk("rdy_fall_e37", bus.ready, 0);
        tick(16);
        chk("rdy_low_mid", bus.ready, 0);
        tick(16);
        chk("rdy_low_e69", bus.ready, 0);
        tick(1);
        chk("rdy_rise_e70", bus.ready, 1);
        chk_results("p2", 16'd21, 16'd77, 16'd133, 16'd189);
        chk_writes("p2", base);
        load_pattern(2);
        tick(36);
        chk("rdy_rise_e107", bus.ready, 1);
        chk_results("wrap", 16'hFFF9, 16'hFFF9, 16'hFFF9, 16'hFFF9);
        load_pattern(0);
        tick(22);
        chk("blk2_re", bus.read_en, 1);
        chk("blk2_addr", bus.addr, 18);
        base = wr_log.size();
        #2 rst_ni = 1'b0;
        #1 chk_idle("midrst");
        tick(2);
        chk_idle("midrst_hold");
        chk("midrst_m23", mem[23], 16'hFFF9);
        chk("midrst_nwr", wr_log.size() - base, 0);
        rst_ni = 1'b1;
        tick(1);
        chk("restart_re", bus.read_en, 1);
        chk("restart_addr", bus.addr, 0);
        tick(31);
        chk("restart_rdy_low", bus.ready, 0);
        tick(1);
        chk("restart_rdy", bus.ready, 1);
        chk_results("p3", 16'd7, 16'd14, 16'd70, 16'd35);
        chk_writes("p3", base);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
